// File: rtl/wb_sram_slave_pkg.sv
// Shared types and constants for the Wishbone SRAM responder.
package wb_sram_slave_pkg;

  localparam int WBS_WAIT_W = 4;

  typedef enum logic [1:0] {
    WBS_IDLE = 2'd0,
    WBS_WAIT = 2'd1,
    WBS_ACK  = 2'd2
  } wbs_state_e;

endpackage

// File: rtl/wb_sram_slave_if.sv
// Wishbone classic bus bundle (16-bit data, 32-bit byte address) for the SRAM responder.
interface wb_sram_slave_if;
  logic [31:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_sram_slave_array.sv
// 2^ADDR_WIDTH x 16 synchronous-read RAM with per-byte write enables (block-RAM style).
module wb_sram_slave_array #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  i_rst,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]            i_we,
  input  logic [15:0]           i_wdata,
  output logic [15:0]           o_rdata
);

  logic [15:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [15:0] r_rdata;

  // i_we[1] is the even (big-endian high) byte, dat[15:8]
  always_ff @(posedge clk_i) begin
    if (i_we[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
    if (i_we[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
  end

  // Output register holds the last read word; its reset maps to the RAM output-latch reset
  always_ff @(posedge clk_i) begin
    if (i_rst)        r_rdata <= '0;
    else if (i_rd_en) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic responder fronting an on-chip big-endian SRAM with programmable wait states.
// Define WB_SRAM_ERR_EN to range-check addresses and terminate misses with wb_err_o instead of aliasing.
module wb_sram_slave
  import wb_sram_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WAIT_STATES = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_sram_slave_if.slave  wb
);

  localparam logic [WBS_WAIT_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? WBS_WAIT_W'(WAIT_STATES - 1) : '0;

  wbs_state_e            r_state;
  logic [WBS_WAIT_W-1:0] r_cnt;
  logic                  r_ack;
  logic                  r_we;
  logic                  r_hit;
  logic [1:0]            r_sel;
  logic [15:0]           r_dat;
  logic [ADDR_WIDTH-1:0] r_idx;

  logic [31:0]           w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [ADDR_WIDTH-1:0] w_arr_addr;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_idle;
  logic                  w_to_ack;
  logic                  w_go_hit;
  logic                  w_go_we;
  logic                  w_rd_en;
  logic [1:0]            w_wr_be;
  logic [15:0]           w_rdata;

  assign w_req = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_off = wb.wb_adr_i - BASE_ADDR;
  assign w_idx = ADDR_WIDTH'(w_off >> 1);

`ifdef WB_SRAM_ERR_EN
  logic r_err;
  assign w_hit       = ((w_off >> (ADDR_WIDTH + 1)) == 32'd0);
  assign wb.wb_err_o = r_err;
`else
  assign w_hit       = 1'b1;
  assign wb.wb_err_o = 1'b0;
`endif

  // The edge that enters ACK also issues the RAM read, so data lands with ack
  assign w_idle     = (r_state == WBS_IDLE);
  assign w_to_ack   = !rst_i && w_req &&
                      ((w_idle && (WAIT_STATES == 0)) || (r_state == WBS_WAIT && r_cnt == '0));
  assign w_go_hit   = w_idle ? w_hit : r_hit;
  assign w_go_we    = w_idle ? wb.wb_we_i : r_we;
  assign w_rd_en    = w_to_ack && w_go_hit && !w_go_we;
  assign w_arr_addr = w_idle ? w_idx : r_idx;
  assign w_wr_be    = (!rst_i && r_state == WBS_ACK && r_we && r_hit) ? r_sel : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= WBS_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
`ifdef WB_SRAM_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_ack <= w_to_ack && w_go_hit;
`ifdef WB_SRAM_ERR_EN
      r_err <= w_to_ack && !w_go_hit;
`endif
      case (r_state)
        WBS_IDLE: begin
          if (w_req) begin
            r_idx <= w_idx;
            r_we  <= wb.wb_we_i;
            r_sel <= wb.wb_sel_i;
            r_dat <= wb.wb_dat_i;
            r_hit <= w_hit;
            if (WAIT_STATES == 0) begin
              r_state <= WBS_ACK;
            end else begin
              r_state <= WBS_WAIT;
              r_cnt   <= WS_LOAD;
            end
          end
        end
        WBS_WAIT: begin
          // Master withdrawing cyc/stb mid-wait abandons the access silently
          if (!w_req) begin
            r_state <= WBS_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_state <= WBS_ACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WBS_ACK:  r_state <= WBS_IDLE;
        default:  r_state <= WBS_IDLE;
      endcase
    end
  end

  wb_sram_slave_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .i_rst   (rst_i),
    .i_rd_en (w_rd_en),
    .i_addr  (w_arr_addr),
    .i_we    (w_wr_be),
    .i_wdata (r_dat),
    .o_rdata (w_rdata)
  );

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = w_rdata;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Randomized bench for wb_sram_slave: three instances (1, 3 and 0 wait states) against a shadow-memory model.
module tb_wb_sram_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          AW   = 12;
  localparam int          WIN  = 1 << (AW + 1);
`ifdef WB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle_no = 0;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_adr [3];
  logic [15:0] m_dat [3];
  logic [1:0]  m_sel [3];
  logic        m_we  [3];
  logic        m_cyc [3];
  logic        m_stb [3];
  logic [2:0][15:0] s_dat;
  logic [2:0]       s_ack;
  logic [2:0]       s_err;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_sram_slave_if bus ();
    assign bus.wb_adr_i = m_adr[g];
    assign bus.wb_dat_i = m_dat[g];
    assign bus.wb_sel_i = m_sel[g];
    assign bus.wb_we_i  = m_we[g];
    assign bus.wb_cyc_i = m_cyc[g];
    assign bus.wb_stb_i = m_stb[g];
    assign s_dat[g]     = bus.wb_dat_o;
    assign s_ack[g]     = bus.wb_ack_o;
    assign s_err[g]     = bus.wb_err_o;

    wb_sram_slave #(
      .ADDR_WIDTH  (AW),
      .BASE_ADDR   (BASE),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .wb    (bus)
    );
  end

  // Shadow memory per instance, plus the word the read port should be holding
  logic [15:0] mdl   [3][4096];
  bit          known [3][4096];
  logic [15:0] lrd   [3];
  bit          lrd_ok[3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      lrd[d]    = 16'h0000;
      lrd_ok[d] = 1'b1;
    end
  endtask

  // One bus access held until ack/err; address phase is scrambled after the request edge.
  task automatic xfer(input int d, input bit we, input logic [31:0] adr, input logic [15:0] wd,
                      input logic [1:0] sel, output logic [15:0] rd, output bit ga, output bit ge,
                      output int lat, output int t_ack);
    @(posedge clk); #1;
    m_adr[d] = adr; m_dat[d] = wd; m_sel[d] = sel; m_we[d] = we;
    m_cyc[d] = 1'b1; m_stb[d] = 1'b1;
    lat = 0; ga = 1'b0; ge = 1'b0;
    while (!ga && !ge && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      ga = s_ack[d];
      ge = s_err[d];
      if (lat == 1 && !ga && !ge) begin
        m_adr[d] = $urandom; m_dat[d] = 16'($urandom);
        m_sel[d] = 2'($urandom_range(0, 3)); m_we[d] = 1'($urandom_range(0, 1));
      end
    end
    t_ack = cycle_no;
    rd = s_dat[d];
    m_cyc[d] = 1'b0; m_stb[d] = 1'b0; m_we[d] = 1'b0;
  endtask

  task automatic do_op(input int d, input bit we, input logic [31:0] adr, input logic [15:0] wd,
                       input logic [1:0] sel, input string tag, output logic [15:0] rd);
    logic [31:0] off;
    int          idx, lat, t;
    bit          hit, ga, ge;
    logic [15:0] tmp;
    off = adr - BASE;
    idx = int'(off[AW:1]);
    hit = ERR_EN ? ((off >> (AW + 1)) == 32'd0) : 1'b1;
    xfer(d, we, adr, wd, sel, rd, ga, ge, lat, t);
    check_val({tag, "_ack"}, 32'(ga), 32'(hit));
    check_val({tag, "_err"}, 32'(ge), 32'(!hit));
    check_val({tag, "_lat"}, 32'(lat), 32'(ws_of(d) + 1));
    if (hit && we) begin
      tmp = mdl[d][idx];
      if (sel[1]) tmp[15:8] = wd[15:8];
      if (sel[0]) tmp[7:0]  = wd[7:0];
      mdl[d][idx]   = tmp;
      known[d][idx] = known[d][idx] || (sel == 2'b11);
    end
    if (hit && !we) begin
      lrd[d]    = mdl[d][idx];
      lrd_ok[d] = known[d][idx];
    end
    if (lrd_ok[d]) check_val({tag, "_dat"}, 32'(rd), 32'(lrd[d]));
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, 32'({s_ack[d], s_err[d]}), 32'd0);
  endtask

  // Start an access then withdraw cyc/stb one cycle after the request edge
  task automatic abort_op(input int d, input bit we, input logic [31:0] adr, input logic [15:0] wd,
                          input string tag);
    int n_term;
    @(posedge clk); #1;
    m_adr[d] = adr; m_dat[d] = wd; m_sel[d] = 2'b11; m_we[d] = we;
    m_cyc[d] = 1'b1; m_stb[d] = 1'b1;
    @(posedge clk); #1;
    m_cyc[d] = 1'b0; m_stb[d] = 1'b0; m_we[d] = 1'b0;
    n_term = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (s_ack[d] || s_err[d]) n_term++;
    end
    check_val({tag, "_noterm"}, 32'(n_term), 32'd0);
    check_val({tag, "_hold"}, 32'(s_dat[d]), 32'(lrd[d]));
  endtask

  initial begin
    logic [15:0] rd, rd2;
    bit          ga, ge;
    int          lat, lat2, t1, t2, n_term, k, i;
    logic [31:0] adr;

    for (int d = 0; d < 3; d++) begin
      m_adr[d] = '0; m_dat[d] = '0; m_sel[d] = '0;
      m_we[d] = 1'b0; m_cyc[d] = 1'b0; m_stb[d] = 1'b0;
      for (int j = 0; j < 4096; j++) begin
        mdl[d][j] = 16'h0000; known[d][j] = 1'b0;
      end
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_val("rst_ack", 32'(s_ack[d]), 32'd0);
      check_val("rst_err", 32'(s_err[d]), 32'd0);
      check_val("rst_dat", 32'(s_dat[d]), 32'd0);
    end
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 16; j++)
        do_op(d, 1'b1, BASE + 32'(2 * j), 16'($urandom), 2'b11, "init", rd);
      do_op(d, 1'b1, BASE + 32'(WIN - 2), 16'($urandom), 2'b11, "init_top", rd);
    end

    // Plain write / read-back, one wait state
    do_op(0, 1'b1, 32'h0000_1002, 16'h1234, 2'b11, "p1_wr", rd);
    do_op(0, 1'b0, 32'h0000_1002, 16'h0000, 2'b11, "p1_rd", rd);
    check_val("p1_val", 32'(rd), 32'h1234);

    // Byte lanes: sel[1] is the even byte dat[15:8]
    do_op(0, 1'b1, 32'h0000_1000, 16'hAABB, 2'b11, "p2_pre", rd);
    do_op(0, 1'b1, 32'h0000_1000, 16'h55CC, 2'b10, "p2_hi", rd);
    do_op(0, 1'b1, 32'h0000_1000, 16'h3366, 2'b01, "p2_lo", rd);
    do_op(0, 1'b0, 32'h0000_1000, 16'h0000, 2'b11, "p2_rd", rd);
    check_val("p2_val", 32'(rd), 32'h5566);
    do_op(0, 1'b1, 32'h0000_1000, 16'h9999, 2'b00, "p2_none", rd);
    do_op(0, 1'b0, 32'h0000_1000, 16'h0000, 2'b11, "p2_rd2", rd);
    check_val("p2_val2", 32'(rd), 32'h5566);

    // Aborts during WAIT (three wait states)
    abort_op(1, 1'b0, 32'h0000_1000, 16'h0000, "p3_rd");
    abort_op(1, 1'b1, 32'h0000_1008, 16'hBAD0, "p3_wr");
    do_op(1, 1'b0, 32'h0000_1008, 16'h0000, 2'b11, "p3_chk", rd);
    do_op(1, 1'b1, 32'h0000_1008, 16'h0F0F, 2'b11, "p3_wr2", rd);
    do_op(1, 1'b0, 32'h0000_1008, 16'h0000, 2'b11, "p3_rd2", rd);
    check_val("p3_val", 32'(rd), 32'h0F0F);

    // Reset in the middle of a write's WAIT phase
    do_op(1, 1'b1, 32'h0000_1004, 16'h0000, 2'b11, "p4_pre", rd);
    do_op(1, 1'b1, 32'h0000_1002, 16'h1234, 2'b11, "p4_pre2", rd);
    do_op(1, 1'b0, 32'h0000_1002, 16'h0000, 2'b11, "p4_rdnz", rd);
    @(posedge clk); #1;
    m_adr[1] = 32'h0000_1004; m_dat[1] = 16'hDEAD; m_sel[1] = 2'b11; m_we[1] = 1'b1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("p4_ack", 32'(s_ack[1]), 32'd0);
    check_val("p4_err", 32'(s_err[1]), 32'd0);
    check_val("p4_dat", 32'(s_dat[1]), 32'd0);
    rst = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
    model_reset();
    n_term = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (s_ack[1] || s_err[1]) n_term++;
    end
    check_val("p4_noterm", 32'(n_term), 32'd0);
    do_op(1, 1'b0, 32'h0000_1004, 16'h0000, 2'b11, "p4_rd", rd);
    check_val("p4_val", 32'(rd), 32'h0000);

    // Reset landing in the ACK cycle drops the write
    xfer(1, 1'b1, 32'h0000_1006, 16'hBEEF, 2'b11, rd, ga, ge, lat, t1);
    check_val("p4b_ack", 32'(ga), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    do_op(1, 1'b0, 32'h0000_1006, 16'h0000, 2'b11, "p4b_rd", rd);
    check_val("p4b_val", 32'(rd), 32'(mdl[1][3]));

    // Zero wait states, back-to-back reads
    xfer(2, 1'b0, 32'h0000_1000, 16'h0000, 2'b11, rd, ga, ge, lat, t1);
    xfer(2, 1'b0, 32'h0000_1002, 16'h0000, 2'b11, rd2, ga, ge, lat2, t2);
    check_val("p5_lat1", 32'(lat), 32'd1);
    check_val("p5_lat2", 32'(lat2), 32'd1);
    check_val("p5_gap", 32'(t2 - t1), 32'd2);
    check_val("p5_rd1", 32'(rd), 32'(mdl[2][0]));
    check_val("p5_rd2", 32'(rd2), 32'(mdl[2][1]));
    lrd[2] = mdl[2][1];
    @(posedge clk); #1;

    // Below-window address: error with range check, alias write without
    do_op(0, 1'b1, 32'h0000_2FFE, 16'h1111, 2'b11, "p6_pre", rd);
    do_op(0, 1'b1, 32'h0000_0FFE, 16'h7777, 2'b11, "p6_wr", rd);
    do_op(0, 1'b0, 32'h0000_2FFE, 16'h0000, 2'b11, "p6_rd", rd);
    check_val("p6_val", 32'(rd), ERR_EN ? 32'h1111 : 32'h7777);

    // Random traffic including aliased/out-of-window addresses
    for (int d = 0; d < 3; d++) begin
      repeat (40) begin
        i = int'($urandom_range(0, 15));
        case ($urandom_range(0, 7))
          0:       k = -1;
          1:       k = 1;
          default: k = 0;
        endcase
        adr = BASE + 32'(2 * i) + 32'(k * WIN) + 32'($urandom_range(0, 1));
        do_op(d, 1'($urandom_range(0, 1)), adr, 16'($urandom), 2'($urandom_range(0, 3)), "rnd", rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
